usb2_ep_bufctl: RTL and testbench

USB2_EP_BUFCTL -- requirements
Module: usb2_ep_bufctl

---
 rtl/usb2_ep_bufctl.sv | 142 ++++++++++++++
 tb/tb_usb2_ep_bufctl.sv | 240 ++++++++++++++++++++++++
 2 files changed

// File: rtl/usb2_ep_bufctl.sv
// rtl/usb2_ep_bufctl.sv - USB2 OUT endpoint double-bank buffer controller; USB2_EPCTL_STATS_EN adds commit/discard counters
module usb2_ep_bufctl #(
   parameter int BANK_AW = 8,
   parameter int MAX_LEN = 256
) (
   input  logic               phy_clk,
   input  logic               reset_n,
   input  logic               xfer_in,
   input  logic [3:0]         xfer_pid,
   input  logic               pkt_crc_ok,
   input  logic               pkt_wren,
   input  logic               toggle_clr,
   output logic               xfer_ready,
   output logic [BANK_AW:0]   buf_wr_addr,
   output logic               buf_wren,
   input  logic [BANK_AW-1:0] app_rd_addr,
   output logic [BANK_AW:0]   buf_rd_addr,
   output logic               rx_valid,
   output logic [8:0]         rx_len,
   input  logic               rx_done,
   output logic               pkt_err,
   output logic [15:0]        stat_commit,
   output logic [15:0]        stat_discard
);

   localparam logic [9:0] MAX_LEN_C = 10'(MAX_LEN);
   localparam logic [3:0] PID_DATA0 = 4'hC;
   localparam logic [3:0] PID_DATA1 = 4'h4;

   typedef enum logic [1:0] {S_IDLE, S_RECV, S_EVAL} state_t;

   state_t     state, state_nx;
   logic       xfer_in_1;
   logic [9:0] byte_cnt;
   logic       ovf;
   logic       crc_q;
   logic [3:0] pid_q;
   logic [1:0] full;
   logic [8:0] len [2];
   logic       wr_bank, rd_bank;
   logic       expected;
   logic       commit, discard, release_bank;
   logic [3:0] exp_pid;

   assign exp_pid      = expected ? PID_DATA1 : PID_DATA0;
   assign buf_wr_addr  = {wr_bank, byte_cnt[BANK_AW-1:0]};
   assign buf_rd_addr  = {rd_bank, app_rd_addr};
   assign buf_wren     = pkt_wren & (state == S_RECV) & ~full[wr_bank] & (byte_cnt < MAX_LEN_C);
   assign rx_valid     = full[rd_bank];
   assign rx_len       = len[rd_bank];
   assign release_bank = rx_done & full[rd_bank];

   // State register; xfer_in_1 keeps tracking xfer_in through reset so a packet in flight is not re-detected
   always_ff @(posedge phy_clk) begin
      xfer_in_1 <= xfer_in;
      if (!reset_n) state <= S_IDLE;
      else          state <= state_nx;
   end

   // Next-state and the EVAL decision: discard reasons outrank the silent retransmit drop
   always_comb begin
      state_nx = state;
      commit   = 1'b0;
      discard  = 1'b0;
      case (state)
         S_IDLE: if (xfer_in & ~xfer_in_1) state_nx = S_RECV;
         S_RECV: if (~xfer_in) state_nx = S_EVAL;
         S_EVAL: begin
            state_nx = S_IDLE;
            if (~crc_q | ovf | full[wr_bank]) discard = 1'b1;
            else if (pid_q == exp_pid)       commit  = 1'b1;
         end
         default: state_nx = S_IDLE;
      endcase
   end

   // Packet reception, bank bookkeeping, data toggle and handshake outputs
   always_ff @(posedge phy_clk) begin
      if (!reset_n) begin
         byte_cnt   <= '0;
         ovf        <= 1'b0;
         crc_q      <= 1'b0;
         pid_q      <= '0;
         full       <= '0;
         len[0]     <= '0;
         len[1]     <= '0;
         wr_bank    <= 1'b0;
         rd_bank    <= 1'b0;
         expected   <= 1'b0;
         xfer_ready <= 1'b0;
         pkt_err    <= 1'b0;
      end else begin
         if (state == S_IDLE && state_nx == S_RECV) begin
            byte_cnt <= '0;
            ovf      <= 1'b0;
         end else if (state == S_RECV && pkt_wren) begin
            if (byte_cnt >= MAX_LEN_C) ovf <= 1'b1;
            if (byte_cnt != 10'd511)   byte_cnt <= byte_cnt + 10'd1;
         end
         if (state == S_RECV && ~xfer_in) begin
            crc_q <= pkt_crc_ok;
            pid_q <= xfer_pid;
         end
         // A commit needs an empty bank and a release needs a full one, so they never hit the same bank
         if (commit) begin
            full[wr_bank] <= 1'b1;
            len[wr_bank]  <= byte_cnt[8:0];
            wr_bank       <= ~wr_bank;
            expected      <= ~expected;
         end
         if (release_bank) begin
            full[rd_bank] <= 1'b0;
            rd_bank       <= ~rd_bank;
         end
         if (toggle_clr) expected <= 1'b0;
         pkt_err    <= discard;
         xfer_ready <= ~full[wr_bank];
      end
   end

`ifdef USB2_EPCTL_STATS_EN
   logic [15:0] cnt_commit, cnt_discard;

   // Saturating packet statistics
   always_ff @(posedge phy_clk) begin
      if (!reset_n) begin
         cnt_commit  <= '0;
         cnt_discard <= '0;
      end else begin
         if (commit  && cnt_commit  != 16'hFFFF) cnt_commit  <= cnt_commit + 16'd1;
         if (discard && cnt_discard != 16'hFFFF) cnt_discard <= cnt_discard + 16'd1;
      end
   end

   assign stat_commit  = cnt_commit;
   assign stat_discard = cnt_discard;
`else
   assign stat_commit  = '0;
   assign stat_discard = '0;
`endif

endmodule

// File: tb/tb_usb2_ep_bufctl.sv
// tb/tb_usb2_ep_bufctl.sv - directed scoreboard testbench for usb2_ep_bufctl
module tb_usb2_ep_bufctl;

   logic        phy_clk = 1'b0;
   logic        reset_n;
   logic        xfer_in;
   logic [3:0]  xfer_pid;
   logic        pkt_crc_ok;
   logic        pkt_wren;
   logic        toggle_clr;
   logic        xfer_ready;
   logic [8:0]  buf_wr_addr;
   logic        buf_wren;
   logic [7:0]  app_rd_addr;
   logic [8:0]  buf_rd_addr;
   logic        rx_valid;
   logic [8:0]  rx_len;
   logic        rx_done;
   logic        pkt_err;
   logic [15:0] stat_commit;
   logic [15:0] stat_discard;

   usb2_ep_bufctl #(.BANK_AW(8), .MAX_LEN(256)) dut (
      .phy_clk(phy_clk), .reset_n(reset_n), .xfer_in(xfer_in), .xfer_pid(xfer_pid),
      .pkt_crc_ok(pkt_crc_ok), .pkt_wren(pkt_wren), .toggle_clr(toggle_clr),
      .xfer_ready(xfer_ready), .buf_wr_addr(buf_wr_addr), .buf_wren(buf_wren),
      .app_rd_addr(app_rd_addr), .buf_rd_addr(buf_rd_addr), .rx_valid(rx_valid),
      .rx_len(rx_len), .rx_done(rx_done), .pkt_err(pkt_err),
      .stat_commit(stat_commit), .stat_discard(stat_discard)
   );

   always #5 phy_clk = ~phy_clk;

   localparam logic [3:0] D0 = 4'hC;
   localparam logic [3:0] D1 = 4'h4;
   localparam int K_DROP = 0, K_COMMIT = 1, K_ERR = 2;

   typedef struct {
      int kind;
      int len;
   } outcome_t;

   outcome_t sbq[$];

   int checks = 0;
   int errors = 0;

   logic       m_full [2];
   int         m_len [2];
   logic       m_wr, m_rd, m_exp;
   int         m_commits, m_discards;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] want);
      checks++;
      assert (obs === want) else begin
         errors++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, want);
      end
   endtask

   function automatic logic [31:0] want_stat(input int c);
`ifdef USB2_EPCTL_STATS_EN
      return 32'(c);
`else
      return (c == c) ? 32'd0 : 32'd1;
`endif
   endfunction

   task automatic step();
      @(posedge phy_clk);
      #1;
   endtask

   task automatic model_reset();
      m_full[0] = 1'b0; m_full[1] = 1'b0;
      m_len[0] = 0;     m_len[1] = 0;
      m_wr = 1'b0; m_rd = 1'b0; m_exp = 1'b0;
      m_commits = 0; m_discards = 0;
   endtask

   task automatic chk_rx(input string tag);
      chk({tag, "_rx_valid"}, rx_valid, m_full[m_rd]);
      if (m_full[m_rd]) chk({tag, "_rx_len"}, rx_len, m_len[m_rd]);
      chk({tag, "_stat_commit"}, stat_commit, want_stat(m_commits));
      chk({tag, "_stat_discard"}, stat_discard, want_stat(m_discards));
   endtask

   task automatic send_pkt(input logic [3:0] pid, input int n, input logic crc,
                           input logic done_eval, input logic clr_eval);
      outcome_t o;
      int       writes;
      int       want_writes;
      logic     want_wren;
      logic     rel;
      o.len = n;
      if (!crc || n > 256 || m_full[m_wr]) o.kind = K_ERR;
      else if (pid == (m_exp ? D1 : D0))   o.kind = K_COMMIT;
      else                                 o.kind = K_DROP;
      sbq.push_back(o);
      want_writes = m_full[m_wr] ? 0 : ((n > 256) ? 256 : n);

      xfer_in = 1'b1; xfer_pid = pid;
      step();
      writes = 0;
      for (int i = 0; i < n; i++) begin
         pkt_wren = 1'b1;
         #1;
         want_wren = !m_full[m_wr] && (i < 256);
         if (buf_wren) writes++;
         if (i < 2 || i == 255 || i == 256 || want_wren != buf_wren)
            chk("buf_wren", buf_wren, want_wren);
         if (want_wren && (i == 0 || i == n - 1 || i == 255))
            chk("buf_wr_addr", buf_wr_addr, {m_wr, 8'(i)});
         step();
      end
      pkt_wren = 1'b0; xfer_in = 1'b0; pkt_crc_ok = crc;
      step();
      pkt_crc_ok = 1'b0; rx_done = done_eval; toggle_clr = clr_eval;
      #1;
      chk("eval_pkt_err", pkt_err, 1'b0);
      chk("eval_rx_valid", rx_valid, m_full[m_rd]);
      rel = done_eval && m_full[m_rd];
      step();
      rx_done = 1'b0; toggle_clr = 1'b0;

      o = sbq.pop_front();
      chk("pkt_err", pkt_err, (o.kind == K_ERR));
      chk("write_count", writes, want_writes);
      if (rel) begin
         m_full[m_rd] = 1'b0;
         m_rd = ~m_rd;
      end
      if (o.kind == K_COMMIT) begin
         m_full[m_wr] = 1'b1;
         m_len[m_wr]  = o.len;
         m_wr  = ~m_wr;
         m_exp = ~m_exp;
         m_commits++;
      end
      if (o.kind == K_ERR) m_discards++;
      if (clr_eval) m_exp = 1'b0;
      chk_rx("commit");
      step();
      chk("pkt_err_pulse", pkt_err, 1'b0);
      chk("xfer_ready", xfer_ready, !m_full[m_wr]);
   endtask

   task automatic release_rd();
      logic rel;
      logic [7:0] a;
      rel = m_full[m_rd];
      rx_done = 1'b1;
      step();
      rx_done = 1'b0;
      if (rel) begin
         m_full[m_rd] = 1'b0;
         m_rd = ~m_rd;
      end
      a = 8'($urandom_range(0, 255));
      app_rd_addr = a;
      #1;
      chk("buf_rd_addr", buf_rd_addr, {m_rd, a});
      chk_rx("release");
   endtask

   initial begin
      reset_n = 1'b0; xfer_in = 1'b0; xfer_pid = D0; pkt_crc_ok = 1'b0;
      pkt_wren = 1'b0; toggle_clr = 1'b0; app_rd_addr = 8'h00; rx_done = 1'b0;
      model_reset();
      repeat (3) step();
      chk("rst_xfer_ready", xfer_ready, 1'b0);
      chk("rst_pkt_err", pkt_err, 1'b0);
      chk("rst_rx_len", rx_len, 9'd0);
      chk_rx("rst");
      reset_n = 1'b1;
      #1;
      chk("rst_ready_c1", xfer_ready, 1'b0);
      step();
      chk("rst_ready_c2", xfer_ready, 1'b1);

      // DATA0 64 bytes commits to bank 0
      send_pkt(D0, 64, 1'b1, 1'b0, 1'b0);
      // DATA1 fills bank 1, then a DATA0 finds no free bank
      send_pkt(D1, 20, 1'b1, 1'b0, 1'b0);
      chk("both_full_ready", xfer_ready, 1'b0);
      send_pkt(D0, 10, 1'b1, 1'b0, 1'b0);
      release_rd();
      release_rd();
      release_rd();
      // retransmit dropped silently; zero-length DATA0 then commits
      send_pkt(D1, 7, 1'b1, 1'b0, 1'b0);
      send_pkt(D0, 0, 1'b1, 1'b0, 1'b0);
      release_rd();
      // bad CRC and oversize packet
      send_pkt(D1, 5, 1'b0, 1'b0, 1'b0);
      send_pkt(D1, 300, 1'b1, 1'b0, 1'b0);
      // toggle_clr coinciding with a commit wins
      send_pkt(D1, 8, 1'b1, 1'b0, 1'b0);
      send_pkt(D0, 4, 1'b1, 1'b0, 1'b1);
      release_rd();
      release_rd();
      send_pkt(D0, 6, 1'b1, 1'b0, 1'b0);
      // release in the same cycle as a commit to the other bank
      send_pkt(D1, 12, 1'b1, 1'b1, 1'b0);
      chk("same_cycle_len", rx_len, 9'd12);

      // reset during byte 10 of a packet
      xfer_in = 1'b1; xfer_pid = D0;
      step();
      for (int i = 0; i < 10; i++) begin
         pkt_wren = 1'b1;
         step();
      end
      reset_n = 1'b0;
      step();
      xfer_in = 1'b0;
      step();
      pkt_wren = 1'b1;
      #1;
      chk("midrst_buf_wren", buf_wren, 1'b0);
      pkt_wren = 1'b0;
      model_reset();
      chk("midrst_xfer_ready", xfer_ready, 1'b0);
      chk("midrst_pkt_err", pkt_err, 1'b0);
      chk("midrst_rx_len", rx_len, 9'd0);
      chk_rx("midrst");
      reset_n = 1'b1;
      #1;
      chk("midrst_ready_c1", xfer_ready, 1'b0);
      step();
      chk("midrst_pkt_err2", pkt_err, 1'b0);
      chk("midrst_ready_c2", xfer_ready, 1'b1);
      send_pkt(D0, 5, 1'b1, 1'b0, 1'b0);
      chk("post_rst_len", rx_len, 9'd5);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
